// File: rtl/serv_csr_pkg.sv
// Shared definitions for the interrupt-capable serial CSR block:
// CSR write-source encodings, mstatus bit positions, mcause layout.
package serv_csr_pkg;

   typedef enum logic [1:0] {
      SRC_CSR = 2'b00,
      SRC_EXT = 2'b01,
      SRC_SET = 2'b10,
      SRC_CLR = 2'b11
   } csr_src_e;

   localparam int MSTATUS_MIE   = 3;
   localparam int MSTATUS_MPIE  = 7;
   localparam int MCAUSE_INT    = 31;
   localparam int MCAUSE_CODE_W = 5;

   // One bit of the CSR read-modify-write datapath.
   function automatic logic csr_op(input csr_src_e src,
                                   input logic     q,
                                   input logic     d);
      logic r;
      case (src)
         SRC_EXT: r = d;
         SRC_SET: r = q | d;
         SRC_CLR: r = q & ~d;
         default: r = q;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/serv_csr_mirq_if.sv
// Serial CSR bus between the control/state logic and the CSR block.
// master: control side (drives i_*); slave: CSR block (drives o_*).
interface serv_csr_mirq_if;

   logic       i_init;
   logic       i_en;
   logic [4:0] i_cnt;
   logic       i_cnt_done;
   logic       i_trap;
   logic       i_mret;
   logic [4:0] i_exc_code;
   logic       i_mstatus_en;
   logic       i_mie_en;
   logic       i_mip_en;
   logic       i_mcause_en;
   logic [1:0] i_csr_source;
   logic       i_csr_d_sel;
   logic       i_csr_imm;
   logic       i_rs1;
   logic       o_new_irq;
   logic       o_csr_in;
   logic       o_q;

   modport master (
      output i_init, i_en, i_cnt, i_cnt_done,
      output i_trap, i_mret, i_exc_code,
      output i_mstatus_en, i_mie_en, i_mip_en, i_mcause_en,
      output i_csr_source, i_csr_d_sel, i_csr_imm, i_rs1,
      input  o_new_irq, o_csr_in, o_q
   );

   modport slave (
      input  i_init, i_en, i_cnt, i_cnt_done,
      input  i_trap, i_mret, i_exc_code,
      input  i_mstatus_en, i_mie_en, i_mip_en, i_mcause_en,
      input  i_csr_source, i_csr_d_sel, i_csr_imm, i_rs1,
      output o_new_irq, o_csr_in, o_q
   );

endinterface

// File: rtl/serv_irq_prio.sv
// Lowest-index-wins priority encoder over the pending interrupt lines.
// Ports: i_req (NIRQ requests), o_valid (any set), o_idx (winner index).
module serv_irq_prio #(
   parameter int NIRQ = 3
) (
   input  logic [NIRQ-1:0] i_req,
   output logic            o_valid,
   output logic [3:0]      o_idx
);

   // Scan from the top so the lowest set index is the last to win.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = 4'd0;
      for (int k = NIRQ - 1; k >= 0; k--) begin
         if (i_req[k]) begin
            o_valid = 1'b1;
            o_idx   = 4'(k);
         end
      end
   end

endmodule

// File: rtl/serv_csr_mirq.sv
// Bit-serial mstatus/mie/mip/mcause with NIRQ prioritized level interrupts.
// Ports: i_clk, i_rst (sync, active high), i_irq[NIRQ], bus (slave).
module serv_csr_mirq
   import serv_csr_pkg::*;
#(
   parameter int NIRQ     = 3,
   parameter int IRQ_BASE = 7
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [NIRQ-1:0] i_irq,
   serv_csr_mirq_if.slave  bus
);

   logic                     mstatus_mie;
   logic                     mstatus_mpie;
   logic [NIRQ-1:0]          mie_q;
   logic [NIRQ-1:0]          mip_q;
   logic                     new_irq_q;
   logic [3:0]               sel_q;
   logic                     mcause_int;
   logic [MCAUSE_CODE_W-1:0] mcause_code;

   logic [31:0] mstatus_w;
   logic [31:0] mie_w;
   logic [31:0] mip_w;
   logic [31:0] mcause_w;
   logic [31:0] rd_w;

   logic            q;
   logic            d;
   logic            wdat;
   logic            mstatus_wr;
   logic            mie_wr;
   logic            mcause_wr;
   logic [NIRQ-1:0] pend;
   logic            pend_v;
   logic [3:0]      pend_idx;
   logic            trap_done;
   logic            mret_done;
   logic            irq_take;
   logic [4:0]      irq_code;

   // Architectural 32-bit views; unimplemented bits read as zero.
   always_comb begin
      mstatus_w               = 32'd0;
      mstatus_w[MSTATUS_MIE]  = mstatus_mie;
      mstatus_w[MSTATUS_MPIE] = mstatus_mpie;
      mie_w                   = 32'd0;
      mip_w                   = 32'd0;
      for (int k = 0; k < NIRQ; k++) begin
         mie_w[IRQ_BASE + k] = mie_q[k];
         mip_w[IRQ_BASE + k] = mip_q[k];
      end
      mcause_w = {mcause_int,
                  {(MCAUSE_INT - MCAUSE_CODE_W){1'b0}},
                  mcause_code};
   end

   always_comb begin
      unique case (1'b1)
         bus.i_mstatus_en: rd_w = mstatus_w;
         bus.i_mie_en:     rd_w = mie_w;
         bus.i_mip_en:     rd_w = mip_w;
         bus.i_mcause_en:  rd_w = mcause_w;
         default:          rd_w = 32'd0;
      endcase
   end

   assign q    = bus.i_en & rd_w[bus.i_cnt];
   assign d    = bus.i_csr_d_sel ? bus.i_csr_imm : bus.i_rs1;
   assign wdat = csr_op(csr_src_e'(bus.i_csr_source), q, d);

   assign mstatus_wr = bus.i_en & bus.i_mstatus_en;
   assign mie_wr     = bus.i_en & bus.i_mie_en;
   assign mcause_wr  = bus.i_en & bus.i_mcause_en;

   assign pend = mip_q & mie_q;

   serv_irq_prio #(
      .NIRQ (NIRQ)
   ) u_prio (
      .i_req   (pend),
      .o_valid (pend_v),
      .o_idx   (pend_idx)
   );

   assign trap_done = bus.i_trap & bus.i_cnt_done;
   assign mret_done = bus.i_mret & bus.i_cnt_done & ~bus.i_trap;

   // A latched request is held (with its channel) until the trap
   // consumes it, so a later drop or a new winner cannot disturb it.
   assign irq_take = bus.i_cnt_done & ~bus.i_init & ~bus.i_trap &
                     ~new_irq_q & mstatus_mie & pend_v;

   assign irq_code = 5'(IRQ_BASE) + 5'(sel_q);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_q        <= '0;
         mip_q        <= '0;
         new_irq_q    <= 1'b0;
         sel_q        <= 4'd0;
         mcause_int   <= 1'b0;
         mcause_code  <= '0;
      end else begin
         mip_q <= i_irq;

         if (mstatus_wr && bus.i_cnt == 5'(MSTATUS_MIE))
            mstatus_mie <= wdat;
         if (mstatus_wr && bus.i_cnt == 5'(MSTATUS_MPIE))
            mstatus_mpie <= wdat;

         for (int k = 0; k < NIRQ; k++)
            if (mie_wr && bus.i_cnt == 5'(IRQ_BASE + k))
               mie_q[k] <= wdat;

         if (mcause_wr && bus.i_cnt == 5'(MCAUSE_INT))
            mcause_int <= wdat;
         for (int b = 0; b < MCAUSE_CODE_W; b++)
            if (mcause_wr && bus.i_cnt == 5'(b))
               mcause_code[b] <= wdat;

         if (irq_take) begin
            new_irq_q <= 1'b1;
            sel_q     <= pend_idx;
         end

         // Placed last so the trap overrides any same-cycle CSR write.
         if (trap_done) begin
            new_irq_q    <= 1'b0;
            mcause_int   <= new_irq_q;
            mcause_code  <= new_irq_q ? irq_code : bus.i_exc_code;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
         end else if (mret_done) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
         end
      end
   end

   assign bus.o_q       = q;
   assign bus.o_csr_in  = wdat;
   assign bus.o_new_irq = new_irq_q;

endmodule

// File: tb/tb_serv_csr_mirq.sv
// Directed bench for serv_csr_mirq with a word-level CSR model.
// Ports: drives the bus interface, i_irq, i_clk and i_rst.
module tb_serv_csr_mirq;
   import serv_csr_pkg::*;

   localparam int NIRQ = 3;
   localparam int BASE = 7;
   localparam logic [31:0] IEMASK = 32'h0000_0380;

   logic            clk = 1'b0;
   logic            rst;
   logic [NIRQ-1:0] irq;

   serv_csr_mirq_if bus ();

   serv_csr_mirq #(
      .NIRQ     (NIRQ),
      .IRQ_BASE (BASE)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .i_irq (irq),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   bit              m_mie;
   bit              m_mpie;
   logic [31:0]     m_ie;
   logic [31:0]     m_cause;
   bit              m_nirq;
   int              m_sel;
   logic [NIRQ-1:0] m_ipreg;

   bit          chk;
   logic        exp_q;
   logic        exp_ci;
   logic        exp_ni;
   int          n_vec;
   int          n_fail;
   logic [31:0] rd;
   logic        ni0;

   function automatic logic [31:0] model_rd(input int csr);
      case (csr)
         1: return {24'd0, m_mpie, 3'd0, m_mie, 3'd0};
         2: return m_ie;
         3: return 32'(m_ipreg) << BASE;
         4: return m_cause;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_mie   = 0;
      m_mpie  = 0;
      m_ie    = 32'd0;
      m_cause = 32'd0;
      m_nirq  = 0;
      m_sel   = 0;
      m_ipreg = '0;
   endtask

   always @(negedge clk) begin
      if (chk) begin
         n_vec++;
         if (bus.o_q !== exp_q || bus.o_csr_in !== exp_ci ||
             bus.o_new_irq !== exp_ni) begin
            n_fail++;
            $display("FAIL cycle cnt=%0d: q/csr_in/new_irq got %b%b%b want %b%b%b",
                     bus.i_cnt, bus.o_q, bus.o_csr_in, bus.o_new_irq,
                     exp_q, exp_ci, exp_ni);
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // One 32-cycle serial instruction; csr 0=none 1=mstatus 2=mie 3=mip 4=mcause
   task automatic instr(input int csr, input logic [1:0] src,
                        input logic [31:0] d, input bit dsel,
                        input bit trap, input bit mret,
                        input logic [4:0] exc, input bit init,
                        input int irq_at, input logic [NIRQ-1:0] irq_new,
                        input int rst_at);
      logic [31:0]     w0, wc, wd;
      logic [NIRQ-1:0] ip_last, pend;
      bit              ab, mie0, mpie0, ni_0, found;
      ab      = 0;
      w0      = model_rd(csr);
      ip_last = m_ipreg;
      for (int c = 0; c < 32; c++) begin
         @(posedge clk);
         #1;
         if (c == irq_at) irq = irq_new;
         rst              = (c == rst_at);
         bus.i_en         = 1'b1;
         bus.i_cnt        = 5'(c);
         bus.i_cnt_done   = (c == 31);
         bus.i_init       = init;
         bus.i_trap       = trap;
         bus.i_mret       = mret;
         bus.i_exc_code   = exc;
         bus.i_mstatus_en = (csr == 1);
         bus.i_mie_en     = (csr == 2);
         bus.i_mip_en     = (csr == 3);
         bus.i_mcause_en  = (csr == 4);
         bus.i_csr_source = src;
         bus.i_csr_d_sel  = dsel;
         bus.i_csr_imm    = dsel ? d[c] : ~d[c];
         bus.i_rs1        = dsel ? ~d[c] : d[c];
         wc    = model_rd(csr);
         exp_q = wc[c];
         case (src)
            2'b00:   exp_ci = exp_q;
            2'b01:   exp_ci = d[c];
            2'b10:   exp_ci = exp_q | d[c];
            default: exp_ci = exp_q & ~d[c];
         endcase
         exp_ni = m_nirq;
         chk    = 1;
         @(negedge clk);
         rd[c] = bus.o_q;
         if (c == 0) ni0 = bus.o_new_irq;
         ip_last = m_ipreg;
         if (rst) begin
            model_reset();
            ab = 1;
            break;
         end
         m_ipreg = irq;
      end
      if (!ab) begin
         case (src)
            2'b00:   wd = w0;
            2'b01:   wd = d;
            2'b10:   wd = w0 | d;
            default: wd = w0 & ~d;
         endcase
         mie0  = m_mie;
         mpie0 = m_mpie;
         ni_0  = m_nirq;
         pend  = ip_last & m_ie[BASE +: NIRQ];
         case (csr)
            1: begin m_mie = wd[3]; m_mpie = wd[7]; end
            2: m_ie = wd & IEMASK;
            4: m_cause = wd & 32'h8000_001F;
            default: ;
         endcase
         if (trap) begin
            m_cause = ni_0 ? (32'h8000_0000 | 32'(BASE + m_sel))
                           : {27'd0, exc};
            m_mpie  = mie0;
            m_mie   = 0;
            m_nirq  = 0;
         end else if (mret) begin
            m_mie  = mpie0;
            m_mpie = 1;
         end
         if (!trap && !init && !ni_0 && mie0 && pend != '0) begin
            m_nirq = 1;
            found  = 0;
            for (int k = 0; k < NIRQ; k++)
               if (pend[k] && !found) begin
                  m_sel = k;
                  found = 1;
               end
         end
      end
   endtask

   task automatic op(input int csr, input logic [1:0] src,
                     input logic [31:0] d, input bit dsel);
      instr(csr, src, d, dsel, 0, 0, 5'd0, 0, -1, irq, -1);
   endtask

   task automatic trap_i(input logic [4:0] exc);
      instr(0, SRC_CSR, 32'd0, 0, 1, 0, exc, 0, -1, irq, -1);
   endtask

   task automatic mret_i();
      instr(0, SRC_CSR, 32'd0, 0, 0, 1, 5'd0, 0, -1, irq, -1);
   endtask

   task automatic set_irq(input logic [NIRQ-1:0] v);
      instr(0, SRC_CSR, 32'd0, 0, 0, 0, 5'd0, 0, 0, v, -1);
   endtask

   task automatic rdck(input string nm, input int csr,
                       input logic [31:0] exp);
      op(csr, SRC_CSR, 32'd0, 0);
      check(nm, rd, exp);
   endtask

   initial begin
      n_vec = 0;
      n_fail = 0;
      chk = 0;
      rst = 1'b1;
      irq = '0;
      bus.i_init = 0; bus.i_en = 0; bus.i_cnt = 0;
      bus.i_cnt_done = 0; bus.i_trap = 0; bus.i_mret = 0;
      bus.i_exc_code = 0; bus.i_mstatus_en = 0; bus.i_mie_en = 0;
      bus.i_mip_en = 0; bus.i_mcause_en = 0; bus.i_csr_source = 0;
      bus.i_csr_d_sel = 0; bus.i_csr_imm = 0; bus.i_rs1 = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_new_irq", {31'd0, bus.o_new_irq}, 32'd0);

      rdck("rst_mstatus", 1, 32'd0);
      rdck("rst_mcause", 4, 32'd0);
      rdck("rst_mie", 2, 32'd0);

      op(2, SRC_EXT, 32'h0000_0100, 0);
      op(1, SRC_SET, 32'h0000_0008, 1);
      set_irq(3'b010);
      trap_i(5'd0);
      check("irq_pending", {31'd0, ni0}, 32'd1);
      rdck("trap_mcause", 4, 32'h8000_0008);
      check("trap_clears", {31'd0, ni0}, 32'd0);
      rdck("trap_mstatus", 1, 32'h0000_0080);

      set_irq(3'b111);
      op(2, SRC_SET, 32'h0000_0280, 0);
      mret_i();
      rdck("mret_mstatus", 1, 32'h0000_0088);
      trap_i(5'd0);
      check("prio_pending", {31'd0, ni0}, 32'd1);
      rdck("prio_mcause", 4, 32'h8000_0007);
      mret_i();
      rdck("mret2_mstatus", 1, 32'h0000_0088);
      set_irq(3'b000);
      trap_i(5'd0);

      trap_i(5'd11);
      rdck("exc_mcause", 4, 32'h0000_000B);
      check("exc_no_irq", {31'd0, ni0}, 32'd0);

      op(1, SRC_SET, 32'hFFFF_FFFF, 0);
      rdck("setall_mstatus", 1, 32'h0000_0088);
      op(2, SRC_EXT, 32'hFFFF_FFFF, 1);
      rdck("mie_mask", 2, IEMASK);
      set_irq(3'b100);
      op(3, SRC_EXT, 32'hFFFF_FFFF, 1);
      rdck("mip_ro", 3, 32'h0000_0200);
      op(4, SRC_EXT, 32'hFFFF_FFFF, 0);
      rdck("mcause_mask", 4, 32'h8000_001F);
      op(4, SRC_CLR, 32'h8000_0005, 1);
      rdck("mcause_clr", 4, 32'h0000_001A);

      set_irq(3'b000);
      trap_i(5'd0);
      check("drop_keeps", {31'd0, ni0}, 32'd1);
      rdck("drop_mcause", 4, 32'h8000_0009);

      mret_i();
      instr(0, SRC_CSR, 32'd0, 0, 0, 0, 5'd0, 1, 0, 3'b001, -1);
      instr(0, SRC_CSR, 32'd0, 0, 1, 0, 5'd3, 0, 5, 3'b010, -1);
      check("init_no_eval", {31'd0, ni0}, 32'd0);
      rdck("trap_exc3", 4, 32'h0000_0003);
      mret_i();
      op(0, SRC_CSR, 32'd0, 0);
      rdck("late_irq_mstatus", 1, 32'h0000_0088);
      check("late_irq_taken", {31'd0, ni0}, 32'd1);

      set_irq(3'b000);
      instr(4, SRC_EXT, 32'hFFFF_FFFF, 0, 0, 0, 5'd0, 0, -1, irq, 10);
      rdck("midrst_mcause", 4, 32'd0);
      check("midrst_new_irq", {31'd0, ni0}, 32'd0);
      rdck("midrst_mstatus", 1, 32'd0);
      rdck("midrst_mie", 2, 32'd0);
      rdck("midrst_mip", 3, 32'd0);

      chk = 0;
      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/serv_csr_mirq.md
SERV_CSR_MIRQ -- requirements
Module: serv_csr_mirq

Interface
REQ-001 Parameter NIRQ, default 3, number of interrupt channels, legal range 1..16.
REQ-002 Parameter IRQ_BASE, default 7, mcause code for channel 0; channel k uses code IRQ_BASE+k; IRQ_BASE+NIRQ SHALL be <= 31.
REQ-003 One clock; reset is synchronous and active-high: i_clk  in  1  clock; i_rst  in  1  synchronous active-high reset.
REQ-004 i_init in 1 init phase; i_en in 1 serial bit valid; i_cnt in 5 current bit index (LSB first); i_cnt_done in 1 last bit of instruction.
REQ-005 i_irq in NIRQ level interrupt requests; i_trap in 1 trap taken; i_mret in 1 mret executing; i_exc_code in 5 synchronous exception code.
REQ-006 i_mstatus_en, i_mie_en, i_mip_en, i_mcause_en in 1 each, one-hot CSR select.
REQ-007 i_csr_source in 2 (00 CSR, 01 EXT, 10 SET, 11 CLR); i_csr_d_sel in 1; i_csr_imm in 1; i_rs1 in 1.
REQ-008 o_new_irq out 1 interrupt request to control; o_csr_in out 1 serial write data; o_q out 1 serial read data.

Function
REQ-009 d = i_csr_d_sel ? i_csr_imm : i_rs1; o_csr_in = EXT: d, SET: o_q|d, CLR: o_q&~d, CSR: o_q.
REQ-010 o_q SHALL be combinational: bit i_cnt of the selected CSR, 0 when no select or i_en low.
REQ-011 mstatus: bit 3 MIE, bit 7 MPIE readable/writable; all other bits read 0, writes ignored.
REQ-012 mie: bit IRQ_BASE+k = enable of channel k; other bits read 0, writes ignored.
REQ-013 mip: bit IRQ_BASE+k = registered i_irq[k] sampled every cycle (1-cycle latency); read-only, writes ignored.
REQ-014 mcause: bit 31 interrupt flag, bits 4:0 code; bits 30:5 read 0; CSR write updates bits on i_en at matching i_cnt.
REQ-015 CSR write of bit b SHALL occur in the cycle i_en & select & i_cnt==b.
REQ-016 At i_cnt_done & !i_init & !i_trap: if any(mip & mie) & MIE, set o_new_irq and latch sel = lowest-index enabled pending channel.
REQ-017 o_new_irq and sel SHALL stay stable until i_trap & i_cnt_done, which clears o_new_irq.
REQ-018 On i_trap & i_cnt_done: mcause = o_new_irq ? {1, IRQ_BASE+sel} : {0, i_exc_code}; MPIE <= MIE; MIE <= 0.
REQ-019 On i_mret (sampled at i_cnt_done): MIE <= MPIE; MPIE <= 1.
REQ-020 Trap update SHALL take priority over a same-cycle CSR write to mstatus or mcause.
REQ-021 An irq dropping after o_new_irq is set SHALL NOT cancel it; trap still reports latched sel.
REQ-022 An irq arriving during the trap instruction SHALL be evaluated at the next non-init i_cnt_done (MIE permitting).

Reset
REQ-023 On i_rst: MIE, MPIE, mie, mip, o_new_irq, sel, mcause all 0; effective next cycle.
REQ-024 Reset mid-instruction SHALL abort any partial CSR write; no state retained.
REQ-025 Outputs after reset: o_new_irq=0, o_q=0 unless CSR selected (reads 0), o_csr_in follows REQ-009.

Structure
REQ-026 CSR source encodings, mstatus bit positions and mcause field widths SHALL live in shared package serv_csr_pkg.
REQ-027 Priority selection SHALL be sub-module serv_irq_prio (NIRQ-wide lowest-index encoder, valid + index out).
REQ-028 No other sub-modules; all state in serv_csr_mirq.

Verification
REQ-029 NIRQ=3: reset, write mie=0x100 (ch1), MIE=1, raise i_irq=3'b010 -> o_new_irq=1 after next i_cnt_done; trap -> mcause=0x80000008, MIE=0, MPIE=1.
REQ-030 i_irq=3'b111, mie all set -> sel=0, mcause=0x80000007; mret -> MIE=1, MPIE=1.
REQ-031 Exception with i_exc_code=11, no irq -> mcause=0x0000000B, o_new_irq stays 0.
REQ-032 CSRRS mstatus with d=0xFFFFFFFF -> read back 0x00000088; CSRRW mip=0xFFFFFFFF -> mip unchanged.
REQ-033 Raise irq, drop it after o_new_irq=1 -> trap still gives irq cause; assert i_rst mid-instruction -> all state 0 next cycle.
